// File: rtl/quadrature_encoder_emulator_pkg.sv
// Shared quadrature definitions: phase encodings, FSM states, direction codes.
// The decoder side imports the same package so both ends agree on CW.
package quadrature_encoder_emulator_pkg;

   typedef enum logic [1:0] {
      PH_00 = 2'd0,
      PH_10 = 2'd1,
      PH_11 = 2'd2,
      PH_01 = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef enum logic {
      DIR_CW  = 1'b0,
      DIR_CCW = 1'b1
   } dir_t;

   function automatic logic [1:0] phase_ab(input phase_t ph);
      logic [1:0] ab;
      case (ph)
         PH_00:   ab = 2'b00;
         PH_10:   ab = 2'b10;
         PH_11:   ab = 2'b11;
         default: ab = 2'b01;
      endcase
      return ab;
   endfunction

   // CW walks the phase sequence forward (A leads), CCW walks it backward.
   function automatic phase_t phase_step(input phase_t ph, input dir_t d);
      logic [1:0] raw;
      raw = (d == DIR_CW) ? (ph + 2'd1) : (ph - 2'd1);
      return phase_t'(raw);
   endfunction

endpackage

// File: rtl/quadrature_encoder_emulator_timer.sv
// Reload down-counter: tick pulses for one cycle every 'period' cycles while
// enabled; load restarts the count so the first tick lands 'period' cycles later.
module quad_step_timer #(
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

   logic [PERIOD_W-1:0] per_q;
   logic [PERIOD_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         per_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         per_q <= period;
         cnt_q <= period - ONE;
      end else if (enable) begin
         cnt_q <= (cnt_q == '0) ? (per_q - ONE) : (cnt_q - ONE);
      end
   end

   assign tick = enable & ~load & (cnt_q == '0);

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Wheel encoder emulator: turns signed step commands into Gray-coded A/B edges
// spaced by a clamped period, tracking net emitted position.
module quadrature_encoder_emulator
   import quadrature_encoder_emulator_pkg::*;
#(
   parameter int unsigned STEPS_W    = 16,
   parameter int unsigned PERIOD_W   = 16,
   parameter int unsigned MIN_PERIOD = 4,
   parameter int unsigned POS_W      = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic signed [STEPS_W-1:0]  cmd_steps,
   input  logic        [PERIOD_W-1:0] cmd_period,
   input  logic                       abort,
   output logic                       A,
   output logic                       B,
   output logic                       busy,
   output logic                       done,
   output logic signed [POS_W-1:0]    position
);

   localparam logic [PERIOD_W-1:0]     MIN_PER = PERIOD_W'(MIN_PERIOD);
   localparam logic [STEPS_W-1:0]      STEP_ONE = STEPS_W'(1);
   localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

   state_t                     state_q, state_d;
   phase_t                     phase_q, phase_d;
   dir_t                       dir_q, dir_d;
   logic [STEPS_W-1:0]         remaining_q, remaining_d;
   logic signed [POS_W-1:0]    position_q, position_d;
   logic [1:0]                 ab_q;

   logic                       handshake;
   logic                       tick;
   logic [STEPS_W-1:0]         steps_u;
   logic [STEPS_W-1:0]         steps_mag;
   logic [PERIOD_W-1:0]        per_clamped;

   assign cmd_ready   = (state_q == ST_IDLE) & ~reset;
   assign handshake   = cmd_valid & cmd_ready;
   assign steps_u     = cmd_steps;
   // Magnitude kept unsigned so the most negative command is representable.
   assign steps_mag   = steps_u[STEPS_W-1] ? ('0 - steps_u) : steps_u;
   assign per_clamped = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;

   quad_step_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (handshake),
      .enable (state_q == ST_RUN),
      .period (per_clamped),
      .tick   (tick)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      dir_d       = dir_q;
      remaining_d = remaining_q;
      position_d  = position_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               dir_d       = steps_u[STEPS_W-1] ? DIR_CCW : DIR_CW;
               remaining_d = steps_mag;
               state_d     = (steps_mag == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (tick) begin
               phase_d     = phase_step(phase_q, dir_q);
               position_d  = (dir_q == DIR_CW) ? (position_q + POS_ONE)
                                               : (position_q - POS_ONE);
               remaining_d = remaining_q - STEP_ONE;
               if (remaining_q == STEP_ONE) state_d = ST_DONE;
            end
            if (abort) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= PH_00;
         dir_q       <= DIR_CW;
         remaining_q <= '0;
         position_q  <= '0;
         ab_q        <= 2'b00;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         dir_q       <= dir_d;
         remaining_q <= remaining_d;
         position_q  <= position_d;
         ab_q        <= phase_ab(phase_d);
      end
   end

   assign A        = ab_q[1];
   assign B        = ab_q[0];
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign position = position_q;

endmodule
